// File: rtl/game_referee.sv
// Game session referee for the 4x4 board: score, move budget, cell coverage, verdict.
// Optional idle timeout enabled by defining GAME_REFEREE_TIMEOUT_EN.
module game_referee #(
  parameter int MAX_MOVES      = 24,
  parameter int TARGET_SCORE   = 40,
  parameter int SCORE_W        = 7,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               move_valid,
  input  logic [3:0]         new_place,
  input  logic [3:0]         prize,
  output logic               move_ready,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         moves_left,
  output logic [4:0]         cells_visited,
  output logic [1:0]         state,
  output logic               game_over,
  output logic               win
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, WON = 2'b10, LOST = 2'b11} state_e;

  localparam int SUM_W = SCORE_W + 5;
  localparam logic [SUM_W-1:0]   SMAX = SUM_W'((1 << SCORE_W) - 1);
  localparam logic [SUM_W-1:0]   TGT  = SUM_W'(TARGET_SCORE);
  localparam logic [7:0]         MAXM = 8'(MAX_MOVES);

  state_e             state_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         left_q, left_d;
  logic [4:0]         cells_q, cells_d;
  logic [15:0]        vis_q, vis_d;
  logic               ready_q, over_q, win_q;
  logic [SUM_W-1:0]   sum;
  logic               new_cell;

  // Next values assuming the move is accepted; the FSM decides whether to commit.
  always_comb begin
    sum      = SUM_W'(score_q) + SUM_W'(prize);
    score_d  = (sum > SMAX) ? '1 : sum[SCORE_W-1:0];
    left_d   = left_q - 8'd1;
    new_cell = ~vis_q[new_place];
    cells_d  = cells_q + {4'd0, new_cell};
    vis_d    = vis_q | (16'd1 << new_place);
  end

`ifdef GAME_REFEREE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TOC = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] idle_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= '0;
      left_q  <= MAXM;
      cells_q <= '0;
      vis_q   <= '0;
      ready_q <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
`ifdef GAME_REFEREE_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else if (start) begin
      // Restart from any state; a coincident move is dropped.
      state_q <= PLAY;
      score_q <= '0;
      left_q  <= MAXM;
      cells_q <= 5'd1;
      vis_q   <= 16'd1;
      ready_q <= 1'b1;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
`ifdef GAME_REFEREE_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else if (state_q == PLAY) begin
      if (move_valid) begin
        score_q <= score_d;
        left_q  <= left_d;
        cells_q <= cells_d;
        vis_q   <= vis_d;
`ifdef GAME_REFEREE_TIMEOUT_EN
        idle_q  <= '0;
`endif
        if (SUM_W'(score_d) >= TGT) begin
          state_q <= WON;
          ready_q <= 1'b0;
          over_q  <= 1'b1;
          win_q   <= 1'b1;
        end else if (left_d == 8'd0 || cells_d == 5'd16) begin
          state_q <= LOST;
          ready_q <= 1'b0;
          over_q  <= 1'b1;
        end
      end
`ifdef GAME_REFEREE_TIMEOUT_EN
      else if (idle_q + 1'b1 == TOC) begin
        state_q <= LOST;
        ready_q <= 1'b0;
        over_q  <= 1'b1;
        idle_q  <= '0;
      end else begin
        idle_q  <= idle_q + 1'b1;
      end
`endif
    end
  end

  assign move_ready    = ready_q;
  assign score         = score_q;
  assign moves_left    = left_q;
  assign cells_visited = cells_q;
  assign state         = state_q;
  assign game_over     = over_q;
  assign win           = win_q;
endmodule

// File: tb/tb_game_referee.sv
// Bench for game_referee: three parameterisations share one stimulus stream and
// are checked every cycle against a rule-level model; directed scenarios add constant checks.
module tb_game_referee;
  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic       reset, start, move_valid;
  logic [3:0] new_place, prize;

  logic       rdy[3], go[3], wn[3];
  logic [6:0] sc[3];
  logic [3:0] sc1;
  logic [7:0] ml[3];
  logic [4:0] cv[3];
  logic [1:0] st[3];

`ifdef GAME_REFEREE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TOC = 8;

  game_referee #(.TIMEOUT_CYCLES(TOC)) u0 (
    .clk(gclk), .reset(reset), .start(start), .move_valid(move_valid),
    .new_place(new_place), .prize(prize), .move_ready(rdy[0]), .score(sc[0]),
    .moves_left(ml[0]), .cells_visited(cv[0]), .state(st[0]), .game_over(go[0]), .win(wn[0]));
  game_referee #(.TARGET_SCORE(10), .SCORE_W(4), .TIMEOUT_CYCLES(TOC)) u1 (
    .clk(gclk), .reset(reset), .start(start), .move_valid(move_valid),
    .new_place(new_place), .prize(prize), .move_ready(rdy[1]), .score(sc1),
    .moves_left(ml[1]), .cells_visited(cv[1]), .state(st[1]), .game_over(go[1]), .win(wn[1]));
  game_referee #(.MAX_MOVES(4), .TIMEOUT_CYCLES(TOC)) u2 (
    .clk(gclk), .reset(reset), .start(start), .move_valid(move_valid),
    .new_place(new_place), .prize(prize), .move_ready(rdy[2]), .score(sc[2]),
    .moves_left(ml[2]), .cells_visited(cv[2]), .state(st[2]), .game_over(go[2]), .win(wn[2]));
  assign sc[1] = {3'd0, sc1};

  // Rule-level model: plain integers and a per-game set of visited cells.
  int P_MAX[3]  = '{24, 24, 4};
  int P_TGT[3]  = '{40, 10, 40};
  int P_SMAX[3] = '{127, 15, 127};
  int m_st[3], m_sc[3], m_ml[3], m_cv[3], m_idle[3];
  bit m_seen[3][16];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_st[k] = 0; m_sc[k] = 0; m_ml[k] = P_MAX[k]; m_cv[k] = 0; m_idle[k] = 0;
        for (int c = 0; c < 16; c++) m_seen[k][c] = 1'b0;
      end else if (start) begin
        m_st[k] = 1; m_sc[k] = 0; m_ml[k] = P_MAX[k]; m_cv[k] = 1; m_idle[k] = 0;
        for (int c = 0; c < 16; c++) m_seen[k][c] = (c == 0);
      end else if (m_st[k] == 1) begin
        if (move_valid) begin
          m_idle[k] = 0;
          m_sc[k] = m_sc[k] + int'(prize);
          if (m_sc[k] > P_SMAX[k]) m_sc[k] = P_SMAX[k];
          m_ml[k] = m_ml[k] - 1;
          if (!m_seen[k][new_place]) begin
            m_seen[k][new_place] = 1'b1;
            m_cv[k] = m_cv[k] + 1;
          end
          if (m_sc[k] >= P_TGT[k]) m_st[k] = 2;
          else if (m_ml[k] == 0 || m_cv[k] == 16) m_st[k] = 3;
        end else if (TO_EN) begin
          m_idle[k] = m_idle[k] + 1;
          if (m_idle[k] == TOC) m_st[k] = 3;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.state", k), int'(st[k]), m_st[k]);
      chk($sformatf("u%0d.score", k), int'(sc[k]), m_sc[k]);
      chk($sformatf("u%0d.moves_left", k), int'(ml[k]), m_ml[k]);
      chk($sformatf("u%0d.cells", k), int'(cv[k]), m_cv[k]);
      chk($sformatf("u%0d.ready", k), int'(rdy[k]), int'(m_st[k] == 1));
      chk($sformatf("u%0d.game_over", k), int'(go[k]), int'(m_st[k] >= 2));
      chk($sformatf("u%0d.win", k), int'(wn[k]), int'(m_st[k] == 2));
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    model_step();
    @(negedge gclk);
    check_all();
  endtask

  task automatic idle(input int n);
    reset = 0; start = 0; move_valid = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go_start();
    reset = 0; start = 1; move_valid = 0;
    tick();
    start = 0;
  endtask

  task automatic mv(input int p, input int z);
    reset = 0; start = 0; move_valid = 1; new_place = 4'(p); prize = 4'(z);
    tick();
    move_valid = 0;
  endtask

  int wp[4] = '{1, 2, 3, 7};
  int wz[4] = '{1, 2, 3, 4};
  int bp[4] = '{1, 0, 1, 5};
  int bz[4] = '{1, 0, 0, 2};

  initial begin
    reset = 1; start = 0; move_valid = 0; new_place = 0; prize = 0;
    tick(); tick();
    chk("rst.state", int'(st[0]), 0);
    chk("rst.score", int'(sc[0]), 0);
    chk("rst.moves_left", int'(ml[0]), 24);
    chk("rst.cells", int'(cv[0]), 0);
    chk("rst.ready", int'(rdy[0]), 0);
    chk("rst.game_over", int'(go[0]), 0);
    mv(5, 3); mv(9, 6);
    chk("idle_move.score", int'(sc[0]), 0);
    chk("idle_move.state", int'(st[0]), 0);

    // Win on u1 (target 10)
    go_start();
    for (int i = 0; i < 4; i++) mv(wp[i], wz[i]);
    chk("win.state", int'(st[1]), 2);
    chk("win.win", int'(wn[1]), 1);
    chk("win.score", int'(sc[1]), 10);
    chk("win.moves_left", int'(ml[1]), 20);
    chk("win.cells", int'(cv[1]), 5);
    chk("win.ready", int'(rdy[1]), 0);

    // Budget loss on u2 (4 moves)
    go_start();
    for (int i = 0; i < 4; i++) mv(bp[i], bz[i]);
    chk("budget.state", int'(st[2]), 3);
    chk("budget.win", int'(wn[2]), 0);
    chk("budget.score", int'(sc[2]), 3);
    chk("budget.moves_left", int'(ml[2]), 0);
    chk("budget.cells", int'(cv[2]), 3);
    mv(9, 5);
    chk("budget.after.moves_left", int'(ml[2]), 0);
    chk("budget.after.score", int'(sc[2]), 3);

    // Revisit on u0
    go_start();
    mv(6, 3);
    chk("revisit.cells1", int'(cv[0]), 2);
    mv(6, 0);
    chk("revisit.cells2", int'(cv[0]), 2);
    chk("revisit.score", int'(sc[0]), 3);
    chk("revisit.moves_left", int'(ml[0]), 22);

    // Saturation on u1 (4-bit score)
    go_start();
    mv(4, 15);
    chk("sat.score", int'(sc[1]), 15);
    chk("sat.state", int'(st[1]), 2);

    // start + move collision, then reset + move collision
    go_start();
    mv(2, 5);
    reset = 0; start = 1; move_valid = 1; new_place = 4'd3; prize = 4'd4;
    tick();
    chk("coll_start.score", int'(sc[0]), 0);
    chk("coll_start.moves_left", int'(ml[0]), 24);
    chk("coll_start.cells", int'(cv[0]), 1);
    chk("coll_start.state", int'(st[0]), 1);
    reset = 1; start = 0; move_valid = 1;
    tick();
    chk("coll_reset.state", int'(st[0]), 0);
    chk("coll_reset.moves_left", int'(ml[0]), 24);
    chk("coll_reset.cells", int'(cv[0]), 0);

    if (TO_EN) begin
      go_start();
      idle(TOC - 1);
      chk("to.before", int'(st[0]), 1);
      idle(1);
      chk("to.expire", int'(st[0]), 3);
      chk("to.moves_left", int'(ml[0]), 24);
      go_start();
      idle(TOC - 2);
      mv(8, 1);
      chk("to.move7", int'(st[0]), 1);
      idle(1);
      chk("to.move7_next", int'(st[0]), 1);
    end

    // Randomised run against the model
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 39) == 0);
      move_valid = ($urandom_range(0, 2) != 0);
      new_place  = 4'($urandom_range(0, 15));
      prize      = 4'($urandom_range(0, 15));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
